pes_usr_seq: RTL
================

PES_USR_SEQ -- requirements
Module: pes_usr_seq

Interface
REQ-001 SHALL take parameter WIDTH, default 4: data width of the driven shift register.
REQ-002 SHALL take parameter SHAMT_W, default 3: width of the shift-amount field.
REQ-003 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1: a request is present.
REQ-006 SHALL have port req_ready, output, 1: the block can accept a request.
REQ-007 SHALL have port req_data, input, WIDTH: word to parallel-load.
REQ-008 SHALL have port req_dir, input, 1: shift direction; 0 = right, 1 = left.
REQ-009 SHALL have port req_shamt, input, SHAMT_W: number of shifts after the load.
REQ-010 SHALL have port usr_in, output, WIDTH: parallel data to the downstream shift register.
REQ-011 SHALL have port usr_cnt, output, 2: mode code to the shift register; 00 hold, 01 shift right, 10 shift left, 11 load.
REQ-012 SHALL have port busy, output, 1: a sequence is in progress.
REQ-013 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-014 SHALL implement an FSM with states IDLE, LOAD, SHIFT and DONE.
REQ-015 SHALL drive req_ready high only in IDLE; a request is accepted on an edge where req_valid and req_ready are both high.
REQ-016 SHALL, on acceptance, capture req_data, req_dir and the effective shift count, then enter LOAD.
REQ-017 SHALL set the effective shift count to min(req_shamt, WIDTH); values above WIDTH are clamped.
REQ-018 SHALL, in LOAD (one cycle), drive usr_cnt = 11 and usr_in = captured data.
REQ-019 SHALL, in SHIFT, drive usr_cnt = 01 when dir = 0 or 10 when dir = 1, for exactly the effective-count number of cycles, decrementing the counter each cycle.
REQ-020 SHALL, in DONE (one cycle), drive usr_cnt = 00 and done = 1, then return to IDLE.
REQ-021 SHALL go directly from LOAD to DONE when the effective count is 0.
REQ-022 SHALL produce, for a request accepted at edge k with count n, the load cycle k+1, shift cycles k+2 .. k+1+n and done in cycle k+2+n.
REQ-023 SHALL drive usr_cnt = 00 and usr_in = 0 in IDLE.
REQ-024 SHALL drive busy high in LOAD, SHIFT and DONE, and low in IDLE.
REQ-025 SHALL ignore req_valid while busy; no request queuing.
REQ-026 SHALL drive all outputs from registers or decode of registered state only, with no combinational path from inputs to outputs.

Reset
REQ-027 SHALL, while rst is low, immediately force state IDLE, usr_cnt = 00, usr_in = 0, done = 0, busy = 0 and counter = 0.
REQ-028 SHALL, on reset assertion mid-sequence, abandon the sequence with no done pulse.
REQ-029 SHALL accept a request no earlier than the first rising edge after rst deasserts.

Configuration
REQ-030 SHALL, with PES_USR_SEQ_ABORT_EN defined, add an input port abort (1 bit); abort high in LOAD or SHIFT forces DONE on the next edge with done = 1, and abort is ignored in IDLE.
REQ-031 SHALL, without PES_USR_SEQ_ABORT_EN, have no abort port and run every sequence to completion.

Structure
REQ-032 SHALL place the state enum and the usr_cnt code constants (HOLD, SHR, SHL, LOAD) in shared package pes_usr_pkg.
REQ-033 SHALL implement the clamp-load and decrement shift counter as sub-module pes_usr_seq_ctr.

Verification
REQ-034 SHALL verify: data = 1011, dir = 0, shamt = 2 -> usr_cnt 11, 01, 01, 00; done in cycle k+4; attached pes_usr holds 0010.
REQ-035 SHALL verify: data = 0011, dir = 1, shamt = 1 -> usr_cnt 11, 10, 00; attached register holds 0110.
REQ-036 SHALL verify: shamt = 0 -> LOAD then DONE; done in cycle k+2; register equals data.
REQ-037 SHALL verify: shamt = 7 with WIDTH = 4 -> exactly 4 shift cycles; register = 0000.
REQ-038 SHALL verify: req_valid held high during busy -> second request accepted only in the cycle after DONE.
REQ-039 SHALL verify: rst low during SHIFT -> all outputs 0 immediately; no done pulse; req_ready high after release.

Source files
------------

// File: rtl/pes_usr_pkg.sv
// Shared types for the usr shift-register sequencer: FSM states and usr_cnt mode codes.
package pes_usr_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] SHR  = 2'b01;
  localparam logic [1:0] SHL  = 2'b10;
  localparam logic [1:0] LOAD = 2'b11;

  function automatic logic [1:0] shift_code(input logic dir);
    return dir ? SHL : SHR;
  endfunction

endpackage

// File: rtl/pes_usr_seq_ctr.sv
// Shift-count register: loads min(shamt, WIDTH), counts down to zero, clears on demand.
module pes_usr_seq_ctr #(
  parameter int WIDTH   = 4,
  parameter int SHAMT_W = 3,
  parameter int CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               dec_i,
  input  logic               clr_i,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               zero_o,
  output logic               last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d, eff;

  // Shifting more than WIDTH times gives the same all-zero result, so clamp.
  always_comb begin
    if (int'(shamt_i) > WIDTH) eff = CNT_W'(WIDTH);
    else                       eff = CNT_W'(shamt_i);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                        cnt_d = '0;
    else if (load_i)                  cnt_d = eff;
    else if (dec_i && cnt_q != '0)    cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);
  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pes_usr_seq.sv
// Sequencer driving a universal shift register: load, then N shifts, then a done pulse.
// Optional abort input enabled by defining PES_USR_SEQ_ABORT_EN.
module pes_usr_seq
  import pes_usr_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_data,
  input  logic               req_dir,
  input  logic [SHAMT_W-1:0] req_shamt,
`ifdef PES_USR_SEQ_ABORT_EN
  input  logic               abort,
`endif
  output logic [WIDTH-1:0]   usr_in,
  output logic [1:0]         usr_cnt,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic             dir_q;
  logic             rdy_q;
  logic             accept, abort_w;
  logic             ctr_load, ctr_dec, ctr_clr, ctr_zero, ctr_last;
  logic [CNT_W-1:0] ctr_cnt;

`ifdef PES_USR_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // rdy_q holds off acceptance until the first edge after reset release.
  assign req_ready = rdy_q && (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;

  pes_usr_seq_ctr #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W),
    .CNT_W   (CNT_W)
  ) u_ctr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ctr_load),
    .shamt_i (req_shamt),
    .dec_i   (ctr_dec),
    .clr_i   (ctr_clr),
    .cnt_o   (ctr_cnt),
    .zero_o  (ctr_zero),
    .last_o  (ctr_last)
  );

  always_comb begin
    state_d  = state_q;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;
    ctr_clr  = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d  = S_LOAD;
        ctr_load = 1'b1;
      end
      S_LOAD: begin
        if (abort_w || ctr_zero) begin
          state_d = S_DONE;
          ctr_clr = 1'b1;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        ctr_dec = 1'b1;
        // Leaving on the last count gives exactly the loaded number of shift cycles.
        if (abort_w || ctr_last) begin
          state_d = S_DONE;
          ctr_clr = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      dir_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      if (accept) begin
        data_q <= req_data;
        dir_q  <= req_dir;
      end
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    usr_cnt = HOLD;
    usr_in  = '0;
    case (state_q)
      S_LOAD: begin
        usr_cnt = LOAD;
        usr_in  = data_q;
      end
      S_SHIFT: usr_cnt = shift_code(dir_q);
      default: usr_cnt = HOLD;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

  logic unused_cnt;
  assign unused_cnt = ^ctr_cnt;

endmodule
